// File: rtl/nn_lstm_cell_framed.sv
// nn_lstm_cell_framed: framed stochastic LSTM cell with saturating gate/state counters
// Inputs : CLK, INIT (async active-low reset), start, clear_state, a, a_last,
//          W_X/SIGN_W_X, W_R/SIGN_W_R, BETA/SIGN_BETA (gate k packed at slice k: f,i,g,o)
// Outputs: gate_bits {o,g,i,f}, state_bit, a_out, busy, step_done, result_count
module nn_lstm_cell_framed #(
    parameter int N         = 4,
    parameter int NR        = 4,
    parameter int ACC_W     = 4,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 5
) (
    input  logic              CLK,
    input  logic              INIT,
    input  logic              start,
    input  logic              clear_state,
    input  logic [N-1:0]      a,
    input  logic [NR-1:0]     a_last,
    input  logic [4*N-1:0]    W_X,
    input  logic [4*N-1:0]    SIGN_W_X,
    input  logic [4*NR-1:0]   W_R,
    input  logic [4*NR-1:0]   SIGN_W_R,
    input  logic [3:0]        BETA,
    input  logic [3:0]        SIGN_BETA,
    output logic [3:0]        gate_bits,
    output logic              state_bit,
    output logic              a_out,
    output logic              busy,
    output logic              step_done,
    output logic [CNT_W-1:0]  result_count
);
    // working width covers accumulator plus the largest per-cycle term sum without overflow
    localparam int SW = ACC_W + $clog2(N + NR + 2) + 2;
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic signed [SW-1:0] AMAX = SW'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [SW-1:0] AMIN = ~AMAX;

    logic signed [ACC_W-1:0] acc [4];
    logic signed [ACC_W-1:0] s_acc;
    logic signed [SW-1:0]    sum [4];
    logic signed [SW-1:0]    nxt [4];
    logic signed [SW-1:0]    s_nxt;
    logic signed [SW-1:0]    term;
    logic [CW-1:0]           cnt;
    logic [CNT_W-1:0]        run;
    logic                    y;

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [SW-1:0] v);
        return v > AMAX ? ACC_W'(AMAX) : v < AMIN ? ACC_W'(AMIN) : v[ACC_W-1:0];
    endfunction

    // strictly positive: sign bit clear and not zero
    always_comb begin
        for (int k = 0; k < 4; k++) gate_bits[k] = !acc[k][ACC_W-1] && |acc[k];
        state_bit = !s_acc[ACC_W-1] && |s_acc;
        y = state_bit & gate_bits[3];
    end

    always_comb begin
        term = '0;
        for (int k = 0; k < 4; k++) begin
            sum[k] = SIGN_BETA[k] ? -SW'(BETA[k]) : SW'(BETA[k]);
            for (int j = 0; j < N; j++) begin
                term = SW'(a[j] & W_X[k*N+j]);
                sum[k] = SIGN_W_X[k*N+j] ? sum[k] - term : sum[k] + term;
            end
            for (int j = 0; j < NR; j++) begin
                term = SW'(a_last[j] & W_R[k*NR+j]);
                sum[k] = SIGN_W_R[k*NR+j] ? sum[k] - term : sum[k] + term;
            end
            nxt[k] = SW'(acc[k]) + sum[k] - SW'(gate_bits[k]);
        end
        s_nxt = SW'(s_acc) + SW'(gate_bits[0] & state_bit) + SW'(gate_bits[1] & gate_bits[2]) - SW'(state_bit);
    end

    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) begin
            busy         <= 1'b0;
            step_done    <= 1'b0;
            a_out        <= 1'b0;
            result_count <= '0;
            cnt          <= '0;
            run          <= '0;
            s_acc        <= '0;
            for (int k = 0; k < 4; k++) acc[k] <= '0;
        end else begin
            step_done <= 1'b0;
            a_out     <= busy & y;
            if (!busy) begin
                if (start) begin
                    busy <= 1'b1;
                    cnt  <= '0;
                    run  <= '0;
                    for (int k = 0; k < 4; k++) acc[k] <= '0;
                    if (clear_state) s_acc <= '0;
                end
            end else begin
                for (int k = 0; k < 4; k++) acc[k] <= sat(nxt[k]);
                s_acc <= sat(s_nxt);
                run   <= run + CNT_W'(y);
                if (cnt == CW'(FRAME_LEN - 1)) begin
                    busy         <= 1'b0;
                    step_done    <= 1'b1;
                    result_count <= run + CNT_W'(y);
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_nn_lstm_cell_framed.sv
// tb_nn_lstm_cell_framed: scoreboard bench for nn_lstm_cell_framed against an integer reference model
module tb_nn_lstm_cell_framed;
    localparam int N = 4, NR = 4, ACC_W = 4, FL = 16, CNT_W = 5;
    localparam int WX = 4 * N, WR = 4 * NR;

    logic CLK = 0, INIT = 0, start = 0, clear_state = 0;
    logic [N-1:0] a = '0;
    logic [NR-1:0] a_last = '0;
    logic [WX-1:0] W_X = '0, SIGN_W_X = '0;
    logic [WR-1:0] W_R = '0, SIGN_W_R = '0;
    logic [3:0] BETA = '0, SIGN_BETA = '0;
    logic [3:0] gate_bits;
    logic state_bit, a_out, busy, step_done;
    logic [CNT_W-1:0] result_count;

    nn_lstm_cell_framed #(.N(N), .NR(NR), .ACC_W(ACC_W), .FRAME_LEN(FL), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .INIT(INIT), .start(start), .clear_state(clear_state), .a(a), .a_last(a_last),
        .W_X(W_X), .SIGN_W_X(SIGN_W_X), .W_R(W_R), .SIGN_W_R(SIGN_W_R), .BETA(BETA), .SIGN_BETA(SIGN_BETA),
        .gate_bits(gate_bits), .state_bit(state_bit), .a_out(a_out), .busy(busy),
        .step_done(step_done), .result_count(result_count)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        logic [N-1:0] a; logic [NR-1:0] al;
        logic [WX-1:0] wx, sx; logic [WR-1:0] wr, sr;
        logic [3:0] b, sb; logic st;
    } stim_t;
    typedef struct { int res; int at; logic ao; } frm_t;

    stim_t stim [FL];
    logic [5:0] cyc_q [$];
    frm_t frm_q [$];
    int total = 0, passed = 0;
    int m_acc [4] = '{0, 0, 0, 0};
    int m_s = 0;

    function automatic int sat(int v);
        int mx = (1 << (ACC_W - 1)) - 1;
        return v > mx ? mx : (v < -mx - 1 ? -mx - 1 : v);
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic clr_stim();
        for (int j = 0; j < FL; j++) stim[j] = '{'0, '0, '0, '0, '0, '0, '0, '0, 1'b0};
    endtask

    // Model the whole frame up front, queue per-cycle and end-of-frame expectations, then drive.
    task automatic issue(input bit clr, input int abort_at);
        bit g [4];
        bit st, y, prev_y;
        int sum, cnt;
        prev_y = 0; cnt = 0;
        if (clr) m_s = 0;
        for (int k = 0; k < 4; k++) m_acc[k] = 0;
        for (int j = 0; j < FL; j++) begin
            for (int k = 0; k < 4; k++) g[k] = m_acc[k] > 0;
            st = m_s > 0;
            y = st && g[3];
            cyc_q.push_back({g[3], g[2], g[1], g[0], st, prev_y});
            cnt += int'(y);
            prev_y = y;
            for (int k = 0; k < 4; k++) begin
                sum = stim[j].b[k] ? (stim[j].sb[k] ? -1 : 1) : 0;
                for (int i = 0; i < N; i++)
                    if (stim[j].a[i] && stim[j].wx[k*N+i]) sum += stim[j].sx[k*N+i] ? -1 : 1;
                for (int i = 0; i < NR; i++)
                    if (stim[j].al[i] && stim[j].wr[k*NR+i]) sum += stim[j].sr[k*NR+i] ? -1 : 1;
                m_acc[k] = sat(m_acc[k] + sum - int'(g[k]));
            end
            m_s = sat(m_s + int'(g[0] && st) + int'(g[1] && g[2]) - int'(st));
        end
        @(negedge CLK);
        start = 1; clear_state = clr;
        for (int j = 0; j < FL; j++) begin
            @(negedge CLK);
            if (j == 0) frm_q.push_back(frm_t'{cnt, cyc + FL, prev_y});
            start = stim[j].st; clear_state = 0;
            a = stim[j].a; a_last = stim[j].al;
            W_X = stim[j].wx; SIGN_W_X = stim[j].sx; W_R = stim[j].wr; SIGN_W_R = stim[j].sr;
            BETA = stim[j].b; SIGN_BETA = stim[j].sb;
            if (j == abort_at) begin
                #2 INIT = 0;
                #1;
                chk("abort_busy", int'(busy), 0);
                chk("abort_a_out", int'(a_out), 0);
                chk("abort_gates", int'({gate_bits, state_bit}), 0);
                cyc_q.delete(); frm_q.delete();
                for (int k = 0; k < 4; k++) m_acc[k] = 0;
                m_s = 0;
                start = 0;
                return;
            end
        end
        @(negedge CLK);
        start = 0;
    endtask

    always @(negedge CLK) begin : monitor
        logic [5:0] e;
        frm_t f;
        if (INIT) begin
            if (busy) begin
                if (cyc_q.size() == 0) chk("cycle_unexpected_busy", 1, 0);
                else begin
                    e = cyc_q.pop_front();
                    chk("cycle_gates_state_aout", int'({gate_bits, state_bit, a_out}), int'(e));
                end
            end
            if (step_done) begin
                if (frm_q.size() == 0) chk("unexpected_step_done", 1, 0);
                else begin
                    f = frm_q.pop_front();
                    chk("frame_result_count", int'(result_count), f.res);
                    chk("frame_done_cycle", cyc, f.at);
                    chk("frame_last_a_out", int'(a_out), int'(f.ao));
                    chk("frame_busy_low", int'(busy), 0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #12;
        chk("reset_busy", int'(busy), 0);
        chk("reset_step_done", int'(step_done), 0);
        chk("reset_a_out", int'(a_out), 0);
        chk("reset_result_count", int'(result_count), 0);
        chk("reset_gates_state", int'({gate_bits, state_bit}), 0);
        @(negedge CLK);
        INIT = 1;

        clr_stim();
        issue(1, -1);
        chk("tp1_result", int'(result_count), 0);

        clr_stim();
        for (int j = 0; j < FL; j++) stim[j].b = 4'b1110;
        issue(1, -1);
        chk("tp2_result", int'(result_count), 14);
        issue(0, -1);
        chk("tp3_result_retained", int'(result_count), 14);
        for (int j = 0; j < FL; j++) stim[j].sb = 4'b1000;
        issue(0, -1);
        chk("tp3_o_negative_result", int'(result_count), 0);

        clr_stim();
        for (int j = 0; j < 6; j++) begin
            stim[j].a = 4'hF;
            stim[j].wx = WX'(16'h000F);
        end
        issue(1, -1);

        clr_stim();
        for (int j = 0; j < FL; j++) stim[j].b = 4'b1110;
        stim[3].st = 1; stim[15].st = 1;
        issue(1, -1);
        chk("tp5_start_ignored_result", int'(result_count), 14);

        for (int r = 0; r < 12; r++) begin
            for (int j = 0; j < FL; j++) begin
                stim[j].a = N'($urandom); stim[j].al = NR'($urandom);
                stim[j].wx = WX'($urandom); stim[j].sx = WX'($urandom);
                stim[j].wr = WR'($urandom); stim[j].sr = WR'($urandom);
                stim[j].b = 4'($urandom); stim[j].sb = 4'($urandom);
                stim[j].st = 1'($urandom_range(0, 3) == 0);
            end
            issue(1'($urandom_range(0, 1)), -1);
        end

        clr_stim();
        for (int j = 0; j < FL; j++) stim[j].b = 4'b1110;
        issue(1, 8);
        repeat (2) @(negedge CLK);
        INIT = 1;
        repeat (20) @(negedge CLK);
        chk("post_abort_result_count", int'(result_count), 0);
        chk("post_abort_busy", int'(busy), 0);

        chk("queues_drained", cyc_q.size() + frm_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
